// File: rtl/uart_rx_frame.sv
// uart_rx_frame
//   UART receiver. Deserialises the asynchronous rx line into bytes and offers
//   them on a single-entry valid/ready holding register. The frame format
//   (bit period, parity mode, stop-bit count) is captured at each start edge,
//   so configuration changes only take effect on the following frame.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   rx                asynchronous serial input, idle high
//   delitel           clk cycles per bit; values below 4 are treated as 4
//   parity_bit_mode   0 none, 1 odd, 2 even, 3 mark, 4 space, 5-7 none
//   stop_bit_num      0 = one stop bit, 1 = two stop bits
//   m_data/m_valid    received byte and its valid flag
//   m_ready           consumer accept
//   err_rx            parity error on the last completed frame
//   err_stop          a stop bit of the last completed frame was sampled low
//   err_rx_dropped    last completed frame was discarded (holding reg full)
module uart_rx_frame #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  input  logic [31:0] delitel,
  input  logic [2:0]  parity_bit_mode,
  input  logic        stop_bit_num,
  output logic [7:0]  m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        err_rx,
  output logic        err_stop,
  output logic        err_rx_dropped
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2
  } state_t;

  // Returns 1 when the sampled parity bit disagrees with the expected value.
  function automatic logic par_mismatch(input logic [2:0] mode,
                                        input logic [7:0] data,
                                        input logic       s);
    case (mode)
      3'd1:    return ~(^data ^ s);
      3'd2:    return ^data ^ s;
      3'd3:    return ~s;
      3'd4:    return s;
      default: return 1'b0;
    endcase
  endfunction

  // Metastability synchroniser; resets to the idle (high) line level.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
    end
  end

  assign rxs = sync_q[SYNC_STAGES-1];

  state_t      state_q;
  logic [31:0] cnt_q;
  logic [31:0] div_q;
  logic [2:0]  par_mode_q;
  logic        two_stop_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shift_q;
  logic        par_err_q;
  logic        frm_err_q;
  logic        rxs_prev_q;
  logic [7:0]  m_data_q;
  logic        m_valid_q;
  logic        err_rx_q;
  logic        err_stop_q;
  logic        err_drop_q;

  logic [31:0] div_eff_d;
  logic [2:0]  par_mode_d;
  logic        start_edge_d;
  logic        cnt_zero_d;
  logic        frm_now_d;
  logic        complete_d;
  logic        load_d;
  logic        drop_d;

  always_comb begin
    div_eff_d    = (delitel < 32'd4) ? 32'd4 : delitel;
    par_mode_d   = (parity_bit_mode > 3'd4) ? 3'd0 : parity_bit_mode;
    start_edge_d = rxs_prev_q & ~rxs;
    cnt_zero_d   = (cnt_q == 32'd0);
    frm_now_d    = frm_err_q | ~rxs;
    complete_d   = cnt_zero_d &&
                   (((state_q == S_STOP1) && !two_stop_q) || (state_q == S_STOP2));
    // A frame may land in a full holding register only if it empties this cycle.
    load_d       = complete_d && (!m_valid_q || m_ready);
    drop_d       = complete_d && m_valid_q && !m_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 32'd0;
      div_q      <= 32'd4;
      par_mode_q <= 3'd0;
      two_stop_q <= 1'b0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'h00;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      rxs_prev_q <= 1'b1;
      m_data_q   <= 8'h00;
      m_valid_q  <= 1'b0;
      err_rx_q   <= 1'b0;
      err_stop_q <= 1'b0;
      err_drop_q <= 1'b0;
    end else begin
      rxs_prev_q <= rxs;

      if (load_d) begin
        m_data_q  <= shift_q;
        m_valid_q <= 1'b1;
      end else if (m_valid_q && m_ready) begin
        m_valid_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          // Edge detection only: a line held low after a framing error
          // must go high again before a new frame can start.
          if (start_edge_d) begin
            state_q    <= S_START;
            cnt_q      <= (div_eff_d >> 1) - 32'd1;
            div_q      <= div_eff_d;
            par_mode_q <= par_mode_d;
            two_stop_q <= stop_bit_num;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
          end
        end

        S_START: begin
          if (cnt_zero_d) begin
            if (!rxs) begin
              state_q    <= S_DATA;
              cnt_q      <= div_q - 32'd1;
              bit_idx_q  <= 3'd0;
              err_rx_q   <= 1'b0;
              err_stop_q <= 1'b0;
              err_drop_q <= 1'b0;
            end else begin
              // Start bit no longer low at mid-bit: treat as a glitch.
              state_q <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_q - 32'd1;
          end
        end

        S_DATA: begin
          if (cnt_zero_d) begin
            shift_q[bit_idx_q] <= rxs;
            cnt_q              <= div_q - 32'd1;
            if (bit_idx_q == 3'd7) begin
              state_q <= (par_mode_q != 3'd0) ? S_PARITY : S_STOP1;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q - 32'd1;
          end
        end

        S_PARITY: begin
          if (cnt_zero_d) begin
            par_err_q <= par_mismatch(par_mode_q, shift_q, rxs);
            cnt_q     <= div_q - 32'd1;
            state_q   <= S_STOP1;
          end else begin
            cnt_q <= cnt_q - 32'd1;
          end
        end

        S_STOP1: begin
          if (cnt_zero_d) begin
            frm_err_q <= frm_now_d;
            if (two_stop_q) begin
              state_q <= S_STOP2;
              cnt_q   <= div_q - 32'd1;
            end else begin
              // Complete at mid-stop so back-to-back frames are not missed.
              state_q    <= S_IDLE;
              err_rx_q   <= par_err_q;
              err_stop_q <= frm_now_d;
              err_drop_q <= drop_d;
            end
          end else begin
            cnt_q <= cnt_q - 32'd1;
          end
        end

        S_STOP2: begin
          if (cnt_zero_d) begin
            frm_err_q  <= frm_now_d;
            state_q    <= S_IDLE;
            err_rx_q   <= par_err_q;
            err_stop_q <= frm_now_d;
            err_drop_q <= drop_d;
          end else begin
            cnt_q <= cnt_q - 32'd1;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign m_data         = m_data_q;
  assign m_valid        = m_valid_q;
  assign err_rx         = err_rx_q;
  assign err_stop       = err_stop_q;
  assign err_rx_dropped = err_drop_q;

endmodule
